axi_line_master: RTL and testbench



---
 rtl/axi_line_master.sv | 175 +++++++++++++++++
 tb/tb_axi_line_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_line_master.sv
// axi_line_master: AXI4 master front-end turning L1 cache requests into line-burst reads, single reads and strobed single writes
// Ports: clk/rst (async active-low) | cache side: req, write, wtype, addr, wdata, cacheable -> rdata, line_data, beat_valid, beat_idx, stall, err
//        AXI side: AW*/W*/B*/AR*/R* channels, ARID/AWID = MASTER_ID
module axi_line_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int MASTER_ID  = 0,
  parameter int LINE_BEATS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req,
  input  logic                           write,
  input  logic [1:0]                     wtype,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic                           cacheable,
  output logic [DATA_W-1:0]              rdata,
  output logic [LINE_BEATS*DATA_W-1:0]   line_data,
  output logic                           beat_valid,
  output logic [$clog2(LINE_BEATS)-1:0]  beat_idx,
  output logic                           stall,
  output logic                           err,
  output logic [ID_W-1:0]                AWID,
  output logic [ADDR_W-1:0]              AWADDR,
  output logic [7:0]                     AWLEN,
  output logic [2:0]                     AWSIZE,
  output logic [1:0]                     AWBURST,
  output logic                           AWVALID,
  input  logic                           AWREADY,
  output logic [DATA_W-1:0]              WDATA,
  output logic [DATA_W/8-1:0]            WSTRB,
  output logic                           WLAST,
  output logic                           WVALID,
  input  logic                           WREADY,
  input  logic [ID_W-1:0]                BID,
  input  logic [1:0]                     BRESP,
  input  logic                           BVALID,
  output logic                           BREADY,
  output logic [ID_W-1:0]                ARID,
  output logic [ADDR_W-1:0]              ARADDR,
  output logic [7:0]                     ARLEN,
  output logic [2:0]                     ARSIZE,
  output logic [1:0]                     ARBURST,
  output logic                           ARVALID,
  input  logic                           ARREADY,
  input  logic [ID_W-1:0]                RID,
  input  logic [DATA_W-1:0]              RDATA,
  input  logic [1:0]                     RRESP,
  input  logic                           RLAST,
  input  logic                           RVALID,
  output logic                           RREADY
);
  localparam int DB    = DATA_W / 8;
  localparam int OFF_W = $clog2(DB);
  localparam int IDX_W = $clog2(LINE_BEATS);
  localparam logic [ID_W-1:0]   MID       = ID_W'(MASTER_ID);
  localparam logic [ADDR_W-1:0] BEAT_MASK = ~ADDR_W'(DB - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(DB * LINE_BEATS - 1);
  localparam logic [2:0] IDLE = 3'd0, AR = 3'd1, R = 3'd2, WR = 3'd3, B = 3'd4, DONE = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic [1:0]        l_type;
  logic              l_cache;
  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  widx;
  logic [OFF_W-1:0]  off;
  logic [DB-1:0]     mask;
  logic              extra;
  logic              aw_pend;
  logic              w_pend;
  logic              mis;

  // a write is rejected when its bytes would spill past the end of the data lane
  assign mis  = write & ((32'(addr[OFF_W-1:0]) +
                (wtype == 2'd0 ? 32'd1 : wtype == 2'd1 ? 32'd2 : 32'd4)) > 32'(DB));
  assign off  = l_addr[OFF_W-1:0];
  assign widx = l_addr[OFF_W +: IDX_W];
  assign last = l_cache ? IDX_W'(LINE_BEATS - 1) : '0;
  assign mask = l_type == 2'd0 ? DB'(1) : l_type == 2'd1 ? DB'(3) : DB'(15);

  assign stall = rst & req & (state != DONE);
  assign rdata = l_cache ? line_data[DATA_W*widx +: DATA_W] : line_data[DATA_W-1:0];

  assign ARVALID = state == AR;
  assign ARID    = ARVALID ? MID : '0;
  assign ARADDR  = ARVALID ? l_addr & (l_cache ? LINE_MASK : BEAT_MASK) : '0;
  assign ARLEN   = (ARVALID & l_cache) ? 8'(LINE_BEATS - 1) : 8'd0;
  assign ARSIZE  = ARVALID ? 3'(OFF_W) : 3'd0;
  assign ARBURST = ARVALID ? 2'b01 : 2'b00;
  assign RREADY  = state == R;

  assign AWVALID = (state == WR) & aw_pend;
  assign AWID    = AWVALID ? MID : '0;
  assign AWADDR  = AWVALID ? l_addr & BEAT_MASK : '0;
  assign AWLEN   = 8'd0;
  assign AWSIZE  = AWVALID ? 3'(OFF_W) : 3'd0;
  assign AWBURST = AWVALID ? 2'b01 : 2'b00;
  assign WVALID  = (state == WR) & w_pend;
  assign WDATA   = WVALID ? l_wdata << {off, 3'b000} : '0;
  assign WSTRB   = WVALID ? mask << off : '0;
  assign WLAST   = WVALID;
  assign BREADY  = state == B;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      l_addr     <= '0;
      l_wdata    <= '0;
      l_type     <= '0;
      l_cache    <= 1'b0;
      cnt        <= '0;
      extra      <= 1'b0;
      aw_pend    <= 1'b0;
      w_pend     <= 1'b0;
      err        <= 1'b0;
      beat_valid <= 1'b0;
      beat_idx   <= '0;
      line_data  <= '0;
    end else begin
      beat_valid <= 1'b0;
      case (state)
        IDLE: if (req) begin
          l_addr  <= addr;
          l_wdata <= wdata;
          l_type  <= wtype;
          l_cache <= cacheable;
          cnt     <= '0;
          extra   <= 1'b0;
          aw_pend <= write;
          w_pend  <= write;
          err     <= mis;
          state   <= mis ? DONE : write ? WR : AR;
        end
        AR: if (ARREADY) state <= R;
        R: if (RVALID) begin
          err <= err | (RRESP != 2'b00) | (RID != MID);
          // beats beyond the expected count are drained without touching the line
          if (extra) begin
            if (RLAST) state <= DONE;
          end else begin
            line_data[DATA_W*cnt +: DATA_W] <= RDATA;
            beat_valid <= 1'b1;
            beat_idx   <= cnt;
            cnt        <= cnt + 1'b1;
            if (cnt == last) begin
              if (RLAST) state <= DONE;
              else begin
                extra <= 1'b1;
                err   <= 1'b1;
              end
            end else if (RLAST) begin
              err   <= 1'b1;
              state <= DONE;
            end
          end
        end
        WR: begin
          if (AWREADY) aw_pend <= 1'b0;
          if (WREADY) w_pend <= 1'b0;
          if ((~aw_pend | AWREADY) & (~w_pend | WREADY)) state <= B;
        end
        B: if (BVALID) begin
          err   <= err | (BRESP != 2'b00) | (BID != MID);
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_axi_line_master.sv
// tb_axi_line_master: randomized self-checking bench for axi_line_master against a behavioural line/response model
module tb_axi_line_master;
  localparam int AW = 32, DW = 32, IW = 4, MID = 0, LB = 4;

  logic clk = 1'b0, rst = 1'b0, req = 1'b0, write = 1'b0, cacheable = 1'b0;
  logic [1:0] wtype = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic [LB*DW-1:0] line_data;
  logic beat_valid, stall, err;
  logic [$clog2(LB)-1:0] beat_idx;
  logic [IW-1:0] AWID, ARID;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, ARSIZE;
  logic [1:0] AWBURST, ARBURST;
  logic AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY;
  logic [DW-1:0] WDATA;
  logic [DW/8-1:0] WSTRB;
  logic AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0, RLAST = 1'b0;
  logic [IW-1:0] BID = '0, RID = '0;
  logic [1:0] BRESP = '0, RRESP = '0;
  logic [DW-1:0] RDATA = '0;

  axi_line_master #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MASTER_ID(MID), .LINE_BEATS(LB)) dut (
    .clk(clk), .rst(rst), .req(req), .write(write), .wtype(wtype), .addr(addr), .wdata(wdata),
    .cacheable(cacheable), .rdata(rdata), .line_data(line_data), .beat_valid(beat_valid),
    .beat_idx(beat_idx), .stall(stall), .err(err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] ref_line [LB];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [LB*DW-1:0] ref_flat();
    logic [LB*DW-1:0] f;
    for (int k = 0; k < LB; k++) f[k*DW +: DW] = ref_line[k];
    return f;
  endfunction

  task automatic do_read(input logic [AW-1:0] a, input logic c, input int ar_dly, input int n_sent,
                         input int bad_beat, input logic bad_rid, input logic [DW-1:0] base, input int abort_at);
    int exp_n, n_acc, pulses;
    logic exp_err;
    logic [AW-1:0] exp_ar;
    exp_n   = c ? LB : 1;
    n_acc   = n_sent < exp_n ? n_sent : exp_n;
    exp_err = (n_sent != exp_n) || (bad_beat >= 0 && bad_beat < n_sent) || bad_rid;
    exp_ar  = c ? (a & ~32'(LB*DW/8 - 1)) : (a & ~32'(DW/8 - 1));
    pulses  = 0;
    req = 1'b1; write = 1'b0; addr = a; cacheable = c;
    @(negedge clk);
    check("ar_valid", ARVALID, 1);
    check("ar_stall", stall, 1);
    check("ar_addr", ARADDR, exp_ar);
    check("ar_len", ARLEN, c ? LB - 1 : 0);
    check("ar_size_burst_id", {ARSIZE, ARBURST, ARID}, {3'd2, 2'b01, 4'(MID)});
    addr = $urandom; cacheable = ~c;
    for (int i = 0; i < ar_dly; i++) begin
      @(negedge clk);
      check("ar_hold", {ARVALID, ARADDR, ARLEN}, {1'b1, exp_ar, 8'(exp_n - 1)});
    end
    ARREADY = 1'b1;
    @(negedge clk);
    ARREADY = 1'b0;
    check("ar_drop", ARVALID, 0);
    for (int k = 0; k < n_sent; k++) begin
      if (k == abort_at) begin
        #2 rst = 1'b0;
        #1;
        check("rst_valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY, beat_valid, err}, 0);
        check("rst_line", line_data, 0);
        for (int j = 0; j < LB; j++) ref_line[j] = '0;
        req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        return;
      end
      if ($urandom_range(0, 2) == 0) begin
        RVALID = 1'b0;
        @(negedge clk);
        check("r_gap_bv", beat_valid, 0);
      end
      check("r_ready", RREADY, 1);
      RVALID = 1'b1; RDATA = base + DW'(k); RLAST = (k == n_sent - 1);
      RRESP = (k == bad_beat) ? 2'b10 : 2'b00;
      RID = bad_rid ? 4'(MID + 1) : 4'(MID);
      @(negedge clk);
      if (k < n_acc) ref_line[k] = base + DW'(k);
      pulses += int'(beat_valid);
      check("r_beat_valid", beat_valid, k < n_acc);
      if (k < n_acc) check("r_beat_idx", beat_idx, k);
    end
    RVALID = 1'b0; RLAST = 1'b0; RRESP = '0; RID = '0;
    check("rd_done_stall", stall, 0);
    check("rd_err", err, exp_err);
    check("rd_rdata", rdata, c ? ref_line[(a / (DW/8)) % LB] : ref_line[0]);
    check("rd_line", line_data, ref_flat());
    check("rd_pulses", pulses, n_acc);
    req = 1'b0;
    @(negedge clk);
    check("rd_idle", {beat_valid, RREADY, ARVALID}, 0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [1:0] t, input logic [DW-1:0] d,
                          input int aw_dly, input int w_dly, input int b_dly, input logic bad_resp, input logic bad_id);
    int off, sz;
    logic bad, aw_done, w_done;
    logic [DW-1:0] exp_wd;
    logic [3:0] exp_st;
    off = int'(a % 4);
    sz  = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
    bad = off + sz > 4;
    exp_wd = d << (8 * off);
    exp_st = 4'(((1 << sz) - 1) << off);
    req = 1'b1; write = 1'b1; wtype = t; addr = a; wdata = d; cacheable = 1'($urandom);
    @(negedge clk);
    if (bad) begin
      check("mis_done_stall", stall, 0);
      check("mis_err", err, 1);
      check("mis_no_traffic", {AWVALID, WVALID, ARVALID}, 0);
    end else begin
      aw_done = 1'b0; w_done = 1'b0;
      addr = $urandom; wdata = $urandom;
      for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
        if (c > 0) @(negedge clk);
        check("w_stall", stall, 1);
        check("aw_valid", AWVALID, !aw_done);
        check("w_valid", WVALID, !w_done);
        if (!aw_done) check("aw_fields", {AWADDR, AWLEN, AWID, AWSIZE, AWBURST}, {a & ~32'h3, 8'd0, 4'(MID), 3'd2, 2'b01});
        if (!w_done) check("w_fields", {WDATA, WSTRB, WLAST}, {exp_wd, exp_st, 1'b1});
        AWREADY = (c >= aw_dly);
        WREADY  = (c >= w_dly);
        if (AWREADY) aw_done = 1'b1;
        if (WREADY) w_done = 1'b1;
      end
      @(negedge clk);
      AWREADY = 1'b0; WREADY = 1'b0;
      for (int c = 0; c < b_dly; c++) begin
        check("b_wait", {BREADY, AWVALID, WVALID, stall}, 4'b1001);
        @(negedge clk);
      end
      check("b_ready", BREADY, 1);
      BVALID = 1'b1; BRESP = bad_resp ? 2'b10 : 2'b00; BID = bad_id ? 4'(MID + 3) : 4'(MID);
      @(negedge clk);
      BVALID = 1'b0; BRESP = '0; BID = '0;
      check("wr_done_stall", stall, 0);
      check("wr_err", err, bad_resp | bad_id);
    end
    check("wr_line_kept", line_data, ref_flat());
    req = 1'b0; write = 1'b0;
    @(negedge clk);
    check("wr_idle", {BREADY, AWVALID, WVALID}, 0);
  endtask

  initial begin
    for (int j = 0; j < LB; j++) ref_line[j] = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {ARVALID, AWVALID, WVALID, BREADY, RREADY, beat_valid, err, stall}, 0);
    check("reset_line", line_data, 0);
    check("reset_rdata", rdata, 0);
    rst = 1'b1;
    @(negedge clk);
    do_read(32'h1008, 1'b1, 3, 4, -1, 1'b0, 32'hA0, -1);
    do_read(32'h2004, 1'b0, 0, 1, -1, 1'b0, 32'h55, -1);
    do_write(32'h3003, 2'd0, 32'hAB, 1, 4, 1, 1'b0, 1'b0);
    do_read(32'h4000, 1'b1, 0, 2, 1, 1'b0, 32'hC0, -1);
    do_write(32'h5003, 2'd1, 32'h1234, 0, 0, 0, 1'b0, 1'b0);
    do_read(32'h6000, 1'b1, 1, 4, -1, 1'b0, 32'hD0, 2);
    do_read(32'h7014, 1'b1, 0, 4, -1, 1'b0, 32'h70, -1);
    do_read(32'h8008, 1'b1, 2, 6, -1, 1'b0, 32'hE0, -1);
    do_read(32'h9004, 1'b0, 1, 1, -1, 1'b1, 32'h99, -1);
    do_write(32'hA002, 2'd1, 32'hBEEF, 0, 0, 2, 1'b1, 1'b0);
    do_write(32'hB000, 2'd2, 32'hCAFEF00D, 3, 0, 0, 1'b0, 1'b1);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        logic c;
        int n, bb;
        c = 1'($urandom);
        n = c ? LB : 1;
        case ($urandom_range(0, 5))
          0: if (c) n = $urandom_range(1, LB - 1);
          1: n = n + $urandom_range(1, 2);
          default: ;
        endcase
        bb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
        do_read($urandom, c, $urandom_range(0, 3), n, bb, $urandom_range(0, 7) == 0, $urandom, -1);
      end else begin
        do_write($urandom, 2'($urandom_range(0, 2)), $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 3), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
